set_assoc_cache_array: RTL
==========================

SET_ASSOC_CACHE_ARRAY -- requirements
Module: set_assoc_cache_array

Interface
REQ-001 SHALL have parameter LineWidth, default 128, line bits (multiple of 8).
REQ-002 SHALL have parameter TagWidth, default 24, stored tag bits.
REQ-003 SHALL have parameter IndexWidth, default 4, set index bits; sets = 2^IndexWidth.
REQ-004 SHALL have parameter WayCount, default 2, ways per set (power of two, >= 2).
REQ-005 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port reqValid  input  1  request present.
REQ-008 SHALL have port reqReady  output  1  request accepted when reqValid && reqReady.
REQ-009 SHALL have port reqCommand  input  2  CacheCommand: None / WriteThrough / Replace / Invalidate.
REQ-010 SHALL have port reqIndex  input  IndexWidth  set select.
REQ-011 SHALL have port reqTag  input  TagWidth  compare/fill tag.
REQ-012 SHALL have port reqWriteData  input  LineWidth  fill or write data.
REQ-013 SHALL have port reqWriteMask  input  LineWidth/8  byte enables, WriteThrough only.
REQ-014 SHALL have port rspValid  output  1  one-cycle response pulse.
REQ-015 SHALL have port rspHit  output  1  tag matched a valid way at lookup.
REQ-016 SHALL have port rspWay  output  max(1,log2(WayCount))  hit way, or filled way for Replace.
REQ-017 SHALL have port rspReadData  output  LineWidth  hit-way line before this command's update; 0 on miss.

Function
REQ-018 SHALL store per set/way: valid bit, tag, line; per set: WayCount-1 tree-PLRU bits; all in flops.
REQ-019 SHALL have FSM states Init and Ready; rst forces Init with sweep counter 0.
REQ-020 In Init, SHALL clear valid and PLRU bits of set[counter] each cycle, increment counter, go to Ready after set 2^IndexWidth-1; reqReady=0 in Init.
REQ-021 In Ready, reqReady SHALL be 1 every cycle (no backpressure).
REQ-022 Lookup SHALL be combinational on accepted request; hit = any way with valid && tag==reqTag; tags unique per set.
REQ-023 Response SHALL be registered: rspValid=1 exactly the cycle after acceptance, 0 otherwise; one response per request.
REQ-024 Array update SHALL occur at the acceptance edge; a request next cycle to same set SHALL observe it (back-to-back, no stall).
REQ-025 None: no array change; on hit, PLRU touch of hit way.
REQ-026 WriteThrough: on hit, bytes with mask=1 replaced from reqWriteData, others kept, PLRU touched; on miss, no change (no allocate).
REQ-027 Replace: on hit, overwrite hit way data, rspHit=1; on miss, victim = lowest-numbered invalid way, else PLRU victim; write tag, data, valid=1; rspHit=0; rspWay = written way; PLRU touched.
REQ-028 Invalidate: on hit, clear valid of hit way, PLRU unchanged; on miss, no change.
REQ-029 PLRU: node bit 0 selects lower half as victim; touch sets each node on way's path to point to the opposite half.
REQ-030 rspHit/rspWay/rspReadData SHALL be 0 when rspValid=0.

Reset
REQ-031 During rst: reqReady=0, rspValid=0, rspHit=0, rspWay=0, rspReadData=0, state Init, counter 0.
REQ-032 rst asserted mid-operation SHALL drop any pending response and restart sweep at set 0; all lines invalid after sweep.
REQ-033 reqReady SHALL first be 1 exactly 2^IndexWidth cycles after the first cycle with rst low.

Verification (WayCount=2, IndexWidth=4, LineWidth=128)
REQ-034 rst high 3 cycles then low -> reqReady=0 for 16 cycles, 1 on 17th; rspValid=0 throughout.
REQ-035 Replace idx 3 tag 0x12 data 0xA..A -> rspHit=0 rspWay=0; None idx 3 tag 0x12 -> rspHit=1 way 0 data 0xA..A; None tag 0x13 -> rspHit=0 data 0.
REQ-036 Replace idx 5 tags 0x1, 0x2 (ways 0,1); None tag 0x1; Replace tag 0x3 -> rspWay=1; None tag 0x2 -> miss; None tag 0x1 -> hit.
REQ-037 Line 0 at idx 7; WriteThrough mask 0x0001 data 0xFF -> next None returns byte0=0xFF, bytes1-15 unchanged; WriteThrough to absent tag -> rspHit=0, array unchanged.
REQ-038 Invalidate hit line then None same tag -> miss; Replace then None same index in consecutive cycles -> hit with new data.
REQ-039 Accept Replace then assert rst next cycle -> no rspValid; after sweep None same tag -> miss.

Source files
------------

// File: rtl/set_assoc_cache_array.sv
// Set-associative cache tag/data array with tree-PLRU replacement.
// Lookup is combinational on the accepted request, array updates land on the
// acceptance edge, and the response appears one cycle later.
module set_assoc_cache_array #(
  parameter int LineWidth  = 128,
  parameter int TagWidth   = 24,
  parameter int IndexWidth = 4,
  parameter int WayCount   = 2,
  localparam int WayW      = (WayCount > 2) ? $clog2(WayCount) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    reqValid,
  output logic                    reqReady,
  input  logic [1:0]              reqCommand,
  input  logic [IndexWidth-1:0]   reqIndex,
  input  logic [TagWidth-1:0]     reqTag,
  input  logic [LineWidth-1:0]    reqWriteData,
  input  logic [LineWidth/8-1:0]  reqWriteMask,
  output logic                    rspValid,
  output logic                    rspHit,
  output logic [WayW-1:0]         rspWay,
  output logic [LineWidth-1:0]    rspReadData
);

  localparam int Sets  = 1 << IndexWidth;
  localparam int Bytes = LineWidth / 8;

  localparam logic [1:0] CmdNone         = 2'd0;
  localparam logic [1:0] CmdWriteThrough = 2'd1;
  localparam logic [1:0] CmdReplace      = 2'd2;
  localparam logic [1:0] CmdInvalidate   = 2'd3;

  typedef enum logic {StInit, StReady} state_e;

  state_e                state_q, state_d;
  logic [IndexWidth-1:0] cnt_q, cnt_d;

  logic [WayCount-1:0]  valid_q [Sets];
  logic [TagWidth-1:0]  tag_q   [Sets][WayCount];
  logic [LineWidth-1:0] data_q  [Sets][WayCount];
  logic [WayCount-2:0]  plru_q  [Sets];

  logic                 accept;
  logic [WayCount-1:0]  hit_vec_p0;
  logic                 hit_p0;
  logic [WayW-1:0]      hit_way_p0, victim_p0, fill_way_p0, rsp_way_p0;
  logic [LineWidth-1:0] rd_data_p0;

  logic                 vld_p1;
  logic                 hit_p1;
  logic [WayW-1:0]      way_p1;
  logic [LineWidth-1:0] data_p1;

  // Walk the tree: a node bit of 0 sends the victim into the lower half.
  function automatic logic [WayW-1:0] plru_victim(input logic [WayCount-2:0] bits);
    logic [WayW-1:0] way;
    logic [WayW-1:0] node;
    way  = '0;
    node = '0;
    for (int l = 0; l < WayW; l++) begin
      way[WayW-1-l] = bits[node];
      node = node + node + WayW'(1) + WayW'(bits[node]);
    end
    return way;
  endfunction

  // Point every node on the touched way's path at the opposite half.
  function automatic logic [WayCount-2:0] plru_touch(input logic [WayCount-2:0] bits,
                                                     input logic [WayW-1:0]     way);
    logic [WayCount-2:0] nb;
    logic [WayW-1:0]     node;
    logic                dir;
    nb   = bits;
    node = '0;
    for (int l = 0; l < WayW; l++) begin
      dir      = way[WayW-1-l];
      nb[node] = ~dir;
      node     = node + node + WayW'(1) + WayW'(dir);
    end
    return nb;
  endfunction

  function automatic logic [LineWidth-1:0] merge_bytes(input logic [LineWidth-1:0] old_line,
                                                       input logic [LineWidth-1:0] new_line,
                                                       input logic [Bytes-1:0]     mask);
    logic [LineWidth-1:0] r;
    r = old_line;
    for (int b = 0; b < Bytes; b++) begin
      if (mask[b]) r[b*8 +: 8] = new_line[b*8 +: 8];
    end
    return r;
  endfunction

  // State and sweep counter register; reset restarts the invalidation sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StInit;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Sweep one set per cycle, then serve requests with no backpressure.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == StInit) begin
      cnt_d = cnt_q + 1'b1;
      if (&cnt_q) state_d = StReady;
    end
  end

  assign reqReady = (state_q == StReady) && !rst;
  assign accept   = reqValid && reqReady;

  // Stage p0: tag compare, hit-way read and victim choice for the addressed set.
  always_comb begin
    hit_vec_p0 = '0;
    hit_way_p0 = '0;
    rd_data_p0 = '0;
    victim_p0  = plru_victim(plru_q[reqIndex]);
    for (int w = WayCount - 1; w >= 0; w--) begin
      hit_vec_p0[w] = valid_q[reqIndex][w] && (tag_q[reqIndex][w] == reqTag);
      if (hit_vec_p0[w]) begin
        hit_way_p0 = WayW'(w);
        rd_data_p0 = data_q[reqIndex][w];
      end
      if (!valid_q[reqIndex][w]) victim_p0 = WayW'(w);
    end
    hit_p0      = |hit_vec_p0;
    fill_way_p0 = hit_p0 ? hit_way_p0 : victim_p0;
    rsp_way_p0  = (reqCommand == CmdReplace) ? fill_way_p0 : hit_way_p0;
  end

  // Array state: sweep clears valid/PLRU, accepted commands update on the same edge.
  always_ff @(posedge clk) begin
    if (!rst && state_q == StInit) begin
      valid_q[cnt_q] <= '0;
      plru_q[cnt_q]  <= '0;
    end else if (accept) begin
      case (reqCommand)
        CmdNone: begin
          if (hit_p0) plru_q[reqIndex] <= plru_touch(plru_q[reqIndex], hit_way_p0);
        end
        CmdWriteThrough: begin
          if (hit_p0) begin
            data_q[reqIndex][hit_way_p0] <= merge_bytes(rd_data_p0, reqWriteData, reqWriteMask);
            plru_q[reqIndex]             <= plru_touch(plru_q[reqIndex], hit_way_p0);
          end
        end
        CmdReplace: begin
          valid_q[reqIndex][fill_way_p0] <= 1'b1;
          tag_q[reqIndex][fill_way_p0]   <= reqTag;
          data_q[reqIndex][fill_way_p0]  <= reqWriteData;
          plru_q[reqIndex]               <= plru_touch(plru_q[reqIndex], fill_way_p0);
        end
        CmdInvalidate: begin
          if (hit_p0) valid_q[reqIndex][hit_way_p0] <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Stage p1: response valid is control and is cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) vld_p1 <= 1'b0;
    else     vld_p1 <= accept;
  end

  // Stage p1: response payload captured from the pre-update lookup.
  always_ff @(posedge clk) begin
    if (accept) begin
      hit_p1  <= hit_p0;
      way_p1  <= rsp_way_p0;
      data_p1 <= rd_data_p0;
    end
  end

  // Reset drops a pending response immediately; payload is zero when not valid.
  assign rspValid    = vld_p1 && !rst;
  assign rspHit      = rspValid && hit_p1;
  assign rspWay      = rspValid ? way_p1 : '0;
  assign rspReadData = rspValid ? data_p1 : '0;

endmodule
